// File: rtl/csr_access_unit.sv
// csr_access_unit: initiator side of the CSR file port.
// Turns Zicsr read-modify-write ops and ECALL/MRET trap accesses from EXU into
// raddr/rdata then wen/waddr/wdata CSR transactions. Returns the old CSR value
// for rd, plus a redirect request/target for traps.
// Optional feature macro: CSR_PERM_EN (blocks writes to the read-only CSR
// space addr[11:10]==2'b11 and reports them through o_out_exc).
module csr_access_unit #(
    parameter int XLEN         = 32,
    parameter int MCAUSE_ECALL = 11
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [2:0]      i_in_op,
    input  logic [11:0]     i_in_addr,
    input  logic [XLEN-1:0] i_in_src,
    input  logic            i_in_src0,
    input  logic [XLEN-1:0] i_in_pc,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_out_rd,
    output logic            o_out_jmp,
    output logic [XLEN-1:0] o_out_dnpc,
    output logic            o_out_exc,
    output logic [11:0]     o_raddr,
    input  logic [XLEN-1:0] i_rdata,
    output logic            o_wen,
    output logic [11:0]     o_waddr,
    output logic [XLEN-1:0] o_wdata
);

    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    localparam logic [11:0] ADDR_MTVEC  = 12'h305;
    localparam logic [11:0] ADDR_MEPC   = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE = 12'h342;

    localparam logic [XLEN-1:0] MCAUSE_VAL = XLEN'(MCAUSE_ECALL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_WR2,
        S_DONE
    } state_t;

    state_t            r_state;

    // Latched request fields (data only, never reset)
    logic [2:0]        r_op;
    logic [11:0]       r_addr;
    logic [XLEN-1:0]   r_src;
    logic              r_src0;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_old;
    logic              r_perm_fault;

    // Registered outputs
    logic              r_in_ready;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_rd;
    logic              r_out_jmp;
    logic [XLEN-1:0]   r_out_dnpc;
    logic              r_out_exc;
    logic [11:0]       r_raddr;
    logic              r_wen;
    logic [11:0]       r_waddr;
    logic [XLEN-1:0]   r_wdata;

    logic              w_is_csr;
    logic              w_is_trap;
    logic              w_wr_req;
    logic              w_perm_block;
    logic              w_wr_live;
    logic [XLEN-1:0]   w_done_rd;
    logic [XLEN-1:0]   w_done_dnpc;

    // CSR address read for each op; reserved ops read nothing.
    function automatic logic [11:0] f_read_addr(input logic [2:0] op, input logic [11:0] addr);
        logic [11:0] a;
        a = 12'h000;
        case (op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: a = addr;
            OP_ECALL:                     a = ADDR_MTVEC;
            OP_MRET:                      a = ADDR_MEPC;
            default:                      a = 12'h000;
        endcase
        return a;
    endfunction

    // Zicsr write value: plain bitwise combine of old value and source.
    function automatic logic [XLEN-1:0] f_rmw(input logic [2:0] op, input logic [XLEN-1:0] old,
                                              input logic [XLEN-1:0] src);
        logic [XLEN-1:0] d;
        d = src;
        case (op)
            OP_CSRRS: d = old | src;
            OP_CSRRC: d = old & ~src;
            default:  d = src;
        endcase
        return d;
    endfunction

    assign w_is_csr  = (r_op == OP_CSRRW) || (r_op == OP_CSRRS) || (r_op == OP_CSRRC);
    assign w_is_trap = (r_op == OP_ECALL) || (r_op == OP_MRET);
    // RS/RC with x0/zimm==0 are pure reads; RW always writes.
    assign w_wr_req  = (r_op == OP_CSRRW) || (((r_op == OP_CSRRS) || (r_op == OP_CSRRC)) && !r_src0);

`ifdef CSR_PERM_EN
    assign w_perm_block = w_wr_req && (r_addr[11:10] == 2'b11);
`else
    assign w_perm_block = 1'b0;
`endif

    assign w_done_rd   = w_is_csr  ? r_old : '0;
    assign w_done_dnpc = w_is_trap ? r_old : '0;

    // FSM sequencing the read, the write(s) and the result handshake.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_rd    <= '0;
            r_out_jmp   <= 1'b0;
            r_out_dnpc  <= '0;
            r_out_exc   <= 1'b0;
            r_raddr     <= '0;
            r_wen       <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
        end else begin
            // CSR port strobes are single-cycle unless set below.
            r_raddr <= '0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            if (i_flush && (r_state != S_IDLE)) begin
                r_state     <= S_IDLE;
                r_in_ready  <= 1'b1;
                r_out_valid <= 1'b0;
                r_out_rd    <= '0;
                r_out_jmp   <= 1'b0;
                r_out_dnpc  <= '0;
                r_out_exc   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_in_valid && !i_flush) begin
                            r_op       <= i_in_op;
                            r_addr     <= i_in_addr;
                            r_src      <= i_in_src;
                            r_src0     <= i_in_src0;
                            r_pc       <= i_in_pc;
                            r_raddr    <= f_read_addr(i_in_op, i_in_addr);
                            r_in_ready <= 1'b0;
                            r_state    <= S_RD;
                        end
                    end
                    S_RD: begin
                        r_old        <= i_rdata;
                        r_perm_fault <= w_perm_block;
                        if (r_op == OP_ECALL) begin
                            r_wen   <= 1'b1;
                            r_waddr <= ADDR_MEPC;
                            r_wdata <= r_pc;
                        end else if (w_wr_req && !w_perm_block) begin
                            r_wen   <= 1'b1;
                            r_waddr <= r_addr;
                            r_wdata <= f_rmw(r_op, i_rdata, r_src);
                        end
                        r_state <= S_WR;
                    end
                    S_WR: begin
                        if (r_op == OP_ECALL) begin
                            r_wen   <= 1'b1;
                            r_waddr <= ADDR_MCAUSE;
                            r_wdata <= MCAUSE_VAL;
                            r_state <= S_WR2;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_out_rd    <= w_done_rd;
                            r_out_jmp   <= w_is_trap;
                            r_out_dnpc  <= w_done_dnpc;
                            r_out_exc   <= r_perm_fault;
                            r_state     <= S_DONE;
                        end
                    end
                    S_WR2: begin
                        r_out_valid <= 1'b1;
                        r_out_rd    <= w_done_rd;
                        r_out_jmp   <= w_is_trap;
                        r_out_dnpc  <= w_done_dnpc;
                        r_out_exc   <= r_perm_fault;
                        r_state     <= S_DONE;
                    end
                    S_DONE: begin
                        if (i_out_ready) begin
                            r_out_valid <= 1'b0;
                            r_out_rd    <= '0;
                            r_out_jmp   <= 1'b0;
                            r_out_dnpc  <= '0;
                            r_out_exc   <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                    default: begin
                        r_in_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // A write registered for this cycle is killed by a same-cycle flush or reset.
    assign w_wr_live = r_wen && !i_flush && i_reset;

    assign o_wen       = w_wr_live;
    assign o_waddr     = w_wr_live ? r_waddr : '0;
    assign o_wdata     = w_wr_live ? r_wdata : '0;
    assign o_raddr     = r_raddr;
    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_rd    = r_out_rd;
    assign o_out_jmp   = r_out_jmp;
    assign o_out_dnpc  = r_out_dnpc;
    assign o_out_exc   = r_out_exc;

endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: bench for csr_access_unit with a CSR file and a
// transaction-timeline reference model. Honours CSR_PERM_EN like the design.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [11:0] in_addr;
    logic [31:0] in_src;
    logic        in_src0;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rd;
    logic        out_jmp;
    logic [31:0] out_dnpc;
    logic        out_exc;
    logic [11:0] raddr;
    logic [31:0] rdata;
    logic        wen;
    logic [11:0] waddr;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    csr_access_unit #(.XLEN(32), .MCAUSE_ECALL(11)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_op(in_op),
        .i_in_addr(in_addr), .i_in_src(in_src), .i_in_src0(in_src0), .i_in_pc(in_pc),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_rd(out_rd),
        .o_out_jmp(out_jmp), .o_out_dnpc(out_dnpc), .o_out_exc(out_exc),
        .o_raddr(raddr), .i_rdata(rdata), .o_wen(wen), .o_waddr(waddr), .o_wdata(wdata)
    );

    // CSR file seen by the DUT, and the model's own copy.
    logic [31:0] csr_mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    assign rdata = csr_mem[raddr];

    int n_checks = 0;
    int n_errors = 0;

    // Model: one in-flight op, k = cycles since acceptance (1 = read cycle).
    bit          m_busy = 1'b0;
    int          m_k = 0;
    logic [2:0]  m_op;
    logic [11:0] m_addr;
    logic [31:0] m_src;
    logic        m_src0;
    logic [31:0] m_pc;
    logic [31:0] m_old;

    // Observations
    logic        obs_valid, obs_rdy;
    logic [11:0] obs_raddr_seen;
    logic [31:0] last_rd, last_dnpc;
    logic        last_jmp, last_exc;
    int          wen_cnt, valid_cnt;
    logic [11:0] wa_q[$];
    logic [31:0] wd_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit perm_hit();
`ifdef CSR_PERM_EN
        return m_addr[11:10] == 2'b11;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit csr_writes();
        return (m_op <= 3'd2) && ((m_op == 3'd0) || !m_src0);
    endfunction

    function automatic int n_writes();
        if (m_op == 3'd3) return 2;
        if (csr_writes() && !perm_hit()) return 1;
        return 0;
    endfunction

    function automatic logic [11:0] read_addr();
        if (m_op <= 3'd2) return m_addr;
        if (m_op == 3'd3) return 12'h305;
        if (m_op == 3'd4) return 12'h341;
        return 12'h000;
    endfunction

    function automatic logic [11:0] wr_addr(input int j);
        if (m_op == 3'd3) return (j == 0) ? 12'h341 : 12'h342;
        return m_addr;
    endfunction

    function automatic logic [31:0] wr_data(input int j);
        if (m_op == 3'd3) return (j == 0) ? m_pc : 32'd11;
        if (m_op == 3'd1) return m_old | m_src;
        if (m_op == 3'd2) return m_old & ~m_src;
        return m_src;
    endfunction

    function automatic int done_k();
        return (m_op == 3'd3) ? 4 : 3;
    endfunction

    // One clock cycle: drive inputs, check outputs at mid-cycle, advance model.
    task automatic cycle(input logic v, input logic [2:0] op, input logic [11:0] a,
                         input logic [31:0] s, input logic s0, input logic [31:0] pc,
                         input logic f, input logic ordy, input logic rn);
        logic        e_rdy, e_valid, e_jmp, e_exc, e_wen;
        logic [11:0] e_raddr, e_waddr;
        logic [31:0] e_rd, e_dnpc, e_wdata;
        logic        p_we;
        logic [11:0] p_wa;
        logic [31:0] p_wd;
        int          j;
        in_valid = v; in_op = op; in_addr = a; in_src = s; in_src0 = s0; in_pc = pc;
        flush = f; out_ready = ordy; rst_n = rn;
        #4;
        e_rdy = !m_busy; e_valid = 1'b0; e_rd = '0; e_jmp = 1'b0; e_dnpc = '0; e_exc = 1'b0;
        e_raddr = '0; e_wen = 1'b0; e_waddr = '0; e_wdata = '0;
        if (m_busy) begin
            if (m_k == 1) e_raddr = read_addr();
            j = m_k - 2;
            if (j >= 0 && j < n_writes() && !f && rn) begin
                e_wen = 1'b1; e_waddr = wr_addr(j); e_wdata = wr_data(j);
            end
            if (m_k >= done_k()) begin
                e_valid = 1'b1;
                e_rd    = (m_op <= 3'd2) ? m_old : 32'd0;
                e_jmp   = (m_op == 3'd3) || (m_op == 3'd4);
                e_dnpc  = e_jmp ? m_old : 32'd0;
                e_exc   = csr_writes() && perm_hit();
            end
        end
        chk("in_ready",  32'(in_ready),  32'(e_rdy));
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("out_rd",    out_rd,         e_rd);
        chk("out_jmp",   32'(out_jmp),   32'(e_jmp));
        chk("out_dnpc",  out_dnpc,       e_dnpc);
        chk("out_exc",   32'(out_exc),   32'(e_exc));
        chk("raddr",     32'(raddr),     32'(e_raddr));
        chk("wen",       32'(wen),       32'(e_wen));
        chk("waddr",     32'(waddr),     32'(e_waddr));
        chk("wdata",     wdata,          e_wdata);
        obs_valid = out_valid; obs_rdy = in_ready;
        if (raddr != 12'h000) obs_raddr_seen = raddr;
        if (out_valid === 1'b1) begin
            last_rd = out_rd; last_dnpc = out_dnpc; last_jmp = out_jmp; last_exc = out_exc;
            valid_cnt++;
        end
        if (wen === 1'b1) begin
            wen_cnt++; wa_q.push_back(waddr); wd_q.push_back(wdata);
        end
        p_we = (wen === 1'b1); p_wa = waddr; p_wd = wdata;
        if (!rn) m_busy = 1'b0;
        else if (!m_busy) begin
            if (v && !f) begin
                m_busy = 1'b1; m_k = 1;
                m_op = op; m_addr = a; m_src = s; m_src0 = s0; m_pc = pc;
            end
        end else if (f) m_busy = 1'b0;
        else begin
            if (m_k == 1) m_old = ref_mem[read_addr()];
            if (e_wen) ref_mem[e_waddr] = e_wdata;
            if (m_k >= done_k()) begin
                if (ordy) m_busy = 1'b0;
            end else m_k++;
        end
        @(posedge clk); #1;
        if (p_we) csr_mem[p_wa] = p_wd;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 3'd0, 12'h000, 32'd0, 1'b0, 32'd0, 1'b0, ordy, 1'b1);
    endtask

    task automatic clear_obs();
        wen_cnt = 0; valid_cnt = 0; wa_q.delete(); wd_q.delete();
        obs_raddr_seen = '0; last_rd = '0; last_dnpc = '0; last_jmp = 1'b0; last_exc = 1'b0;
    endtask

    // Issue one op with out_ready held high; lat = cycles from accept to out_valid.
    task automatic run_op(input logic [2:0] op, input logic [11:0] a, input logic [31:0] s,
                          input logic s0, input logic [31:0] pc, output int lat);
        clear_obs();
        lat = -1;
        cycle(1'b1, op, a, s, s0, pc, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            idle(1'b1);
            if (obs_valid === 1'b1 && lat < 0) lat = i;
        end
    endtask

    task automatic set_csr(input logic [11:0] a, input logic [31:0] d);
        csr_mem[a] = d; ref_mem[a] = d;
    endtask

    function automatic logic [11:0] pick_addr(input int k);
        case (k)
            0: return 12'h300;
            1: return 12'h341;
            2: return 12'h342;
            3: return 12'h305;
            4: return 12'hC00;
            default: return 12'h340;
        endcase
    endfunction

    initial begin
        int lat;
        for (int i = 0; i < 4096; i++) begin
            csr_mem[i] = $urandom;
            ref_mem[i] = csr_mem[i];
        end
        in_valid = 1'b0; in_op = '0; in_addr = '0; in_src = '0; in_src0 = 1'b0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clear_obs();

        // Reset state
        idle(1'b0);
        chk("reset_in_ready", 32'(obs_rdy), 32'd1);
        chk("reset_out_valid", 32'(obs_valid), 32'd0);

        // CSRRW 0x300
        set_csr(12'h300, 32'h0000_1800);
        run_op(3'd0, 12'h300, 32'h0000_1888, 1'b0, 32'd0, lat);
        chk("rw_lat", 32'(lat), 32'd3);
        chk("rw_raddr", 32'(obs_raddr_seen), 32'h300);
        chk("rw_rd", last_rd, 32'h0000_1800);
        chk("rw_mem", csr_mem[12'h300], 32'h0000_1888);

        // CSRRS 0x300, then the x0 form
        set_csr(12'h300, 32'h0000_1800);
        run_op(3'd1, 12'h300, 32'h0000_0008, 1'b0, 32'd0, lat);
        chk("rs_wdata", wd_q[0], 32'h0000_1808);
        chk("rs_rd", last_rd, 32'h0000_1800);
        run_op(3'd1, 12'h300, 32'h0000_0008, 1'b1, 32'd0, lat);
        chk("rs0_wen_cnt", 32'(wen_cnt), 32'd0);
        chk("rs0_rd", last_rd, 32'h0000_1808);

        // CSRRC mepc
        set_csr(12'h341, 32'h8000_001F);
        run_op(3'd2, 12'h341, 32'h0000_000F, 1'b0, 32'd0, lat);
        chk("rc_mem", csr_mem[12'h341], 32'h8000_0010);
        chk("rc_rd", last_rd, 32'h8000_001F);

        // ECALL
        set_csr(12'h305, 32'h8000_0400);
        run_op(3'd3, 12'h123, 32'h0, 1'b0, 32'h8000_0100, lat);
        chk("ecall_lat", 32'(lat), 32'd4);
        chk("ecall_wa0", 32'(wa_q[0]), 32'h341);
        chk("ecall_wd0", wd_q[0], 32'h8000_0100);
        chk("ecall_wa1", 32'(wa_q[1]), 32'h342);
        chk("ecall_wd1", wd_q[1], 32'd11);
        chk("ecall_jmp", 32'(last_jmp), 32'd1);
        chk("ecall_dnpc", last_dnpc, 32'h8000_0400);
        chk("ecall_rd", last_rd, 32'd0);

        // MRET with result back-pressure
        set_csr(12'h341, 32'h8000_0104);
        clear_obs();
        cycle(1'b1, 3'd4, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b0);
        chk("mret_hold_valid", 32'(obs_valid), 32'd1);
        chk("mret_hold_rdy", 32'(obs_rdy), 32'd0);
        chk("mret_dnpc", last_dnpc, 32'h8000_0104);
        chk("mret_wen_cnt", 32'(wen_cnt), 32'd0);
        idle(1'b1);
        idle(1'b1);
        chk("mret_release_rdy", 32'(obs_rdy), 32'd1);

        // Flush during the read cycle of CSRRW
        set_csr(12'h300, 32'h0000_1800);
        clear_obs();
        cycle(1'b1, 3'd0, 12'h300, 32'h0000_1234, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 3'd0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        chk("flush_rdy", 32'(obs_rdy), 32'd1);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("flush_wen_cnt", 32'(wen_cnt), 32'd0);
        chk("flush_valid_cnt", 32'(valid_cnt), 32'd0);
        chk("flush_mem", csr_mem[12'h300], 32'h0000_1800);

        // Flush in IDLE drops the request
        clear_obs();
        cycle(1'b1, 3'd0, 12'h300, 32'h5, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("idle_flush_valid_cnt", 32'(valid_cnt), 32'd0);

        // Write to read-only CSR space
        set_csr(12'hF11, 32'h7973_7978);
        run_op(3'd0, 12'hF11, 32'hDEAD_BEEF, 1'b0, 32'h0, lat);
        chk("ro_rd", last_rd, 32'h7973_7978);
`ifdef CSR_PERM_EN
        chk("ro_wen_cnt", 32'(wen_cnt), 32'd0);
        chk("ro_exc", 32'(last_exc), 32'd1);
`else
        chk("ro_wen_cnt", 32'(wen_cnt), 32'd1);
        chk("ro_exc", 32'(last_exc), 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                  pick_addr(int'($urandom_range(0, 5))), $urandom, $urandom_range(0, 3) == 0,
                  $urandom, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 199) != 0);
        end
        for (int i = 0; i < 8; i++) idle(1'b1);
        for (int i = 0; i < 4096; i++) begin
            if (csr_mem[i] !== ref_mem[i]) chk("csr_file", csr_mem[i], ref_mem[i]);
        end
        chk("csr_file_mstatus", csr_mem[12'h300], ref_mem[12'h300]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
